// File: rtl/mult_hilo_ctrl_if.sv
// Execute-stage / multiplier / HI-LO bundle for mult_hilo_ctrl.
// master = core plus array multiplier side, slave = the sequencer itself.
interface mult_hilo_ctrl_if;
  logic        start;
  logic        op_signed;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_p;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op_signed, rs_val, rt_val, mul_p, hi_we, lo_we, wdata,
    input  mul_a, mul_b, busy, done, hi, lo
  );

  modport slave (
    input  start, op_signed, rs_val, rt_val, mul_p, hi_we, lo_we, wdata,
    output mul_a, mul_b, busy, done, hi, lo
  );
endinterface

// File: rtl/mult_hilo_ctrl.sv
// Multi-cycle MULT/MULTU sequencer and HI/LO register owner for CPU54.
// Signed MULT support is built only when MULT_SIGNED_EN is defined.
module mult_hilo_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  mult_hilo_ctrl_if.slave bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] mul_a_q, mul_a_d;
  logic [31:0] mul_b_q, mul_b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

`ifdef MULT_SIGNED_EN
  logic        neg_q, neg_d;

  // 0x80000000 maps to itself, which is its correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    if (v[31]) begin
      abs32 = ~v + 32'd1;
    end else begin
      abs32 = v;
    end
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    neg64 = ~v + 64'd1;
  endfunction
`endif

  // Next-state, operand latch and HI/LO update logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
`ifdef MULT_SIGNED_EN
    neg_d   = neg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.hi_we) begin
          hi_d = bus.wdata;
        end else begin
          hi_d = hi_q;
        end
        if (bus.lo_we) begin
          lo_d = bus.wdata;
        end else begin
          lo_d = lo_q;
        end
        if (bus.start) begin
`ifdef MULT_SIGNED_EN
          if (bus.op_signed) begin
            mul_a_d = abs32(bus.rs_val);
            mul_b_d = abs32(bus.rt_val);
            neg_d   = bus.rs_val[31] ^ bus.rt_val[31];
          end else begin
            mul_a_d = bus.rs_val;
            mul_b_d = bus.rt_val;
            neg_d   = 1'b0;
          end
`else
          mul_a_d = bus.rs_val;
          mul_b_d = bus.rt_val;
`endif
          cnt_d   = CNT_INIT;
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
`ifdef MULT_SIGNED_EN
          if (neg_q) begin
            {hi_d, lo_d} = neg64(bus.mul_p);
          end else begin
            {hi_d, lo_d} = bus.mul_p;
          end
`else
          {hi_d, lo_d} = bus.mul_p;
`endif
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight multiply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      mul_a_q <= 32'd0;
      mul_b_q <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
`ifdef MULT_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
`ifdef MULT_SIGNED_EN
      neg_q   <= neg_d;
`endif
    end
  end

  assign bus.busy  = (state_q == S_WAIT);
  assign bus.done  = done_q;
  assign bus.mul_a = mul_a_q;
  assign bus.mul_b = mul_b_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Scoreboard bench for mult_hilo_ctrl: random and corner multiplies checked
// against a sign-extend-and-multiply reference model.
module tb_mult_hilo_ctrl;
  localparam int unsigned W = 2;

  logic clk;
  logic rst_n;
  mult_hilo_ctrl_if bus();

  int checks;
  int fails;
  logic [63:0] exp_q[$];
  bit done_prev;

  mult_hilo_ctrl #(.WAIT_CYCLES(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Stand-in for the combinational array multiplier.
  assign bus.mul_p = {32'd0, bus.mul_a} * {32'd0, bus.mul_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_prod(input bit sg, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ax, bx;
    ax = {32'd0, a};
    bx = {32'd0, b};
`ifdef MULT_SIGNED_EN
    if (sg) begin
      ax = {{32{a[31]}}, a};
      bx = {{32{b[31]}}, b};
    end
`endif
    return ax * bx;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding product.
  always @(negedge clk) begin
    if (!rst_n) begin
      done_prev = 1'b0;
    end else begin
      if (bus.done) begin
        chk("done_single_cycle", 64'(done_prev), 64'd0);
        if (exp_q.size() == 0) begin
          chk("spurious_done", 64'd1, 64'd0);
        end else begin
          chk("hilo_product", {bus.hi, bus.lo}, exp_q.pop_front());
        end
      end
      done_prev = bus.done;
    end
  end

  task automatic do_mult(input bit sg, input logic [31:0] a, input logic [31:0] b,
                         input bit inj, input bit lowe, input bit hiws);
    int n;
    logic [31:0] lo_before;
    logic [31:0] w;
    n = 0;
    while (bus.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    lo_before = bus.lo;
    w = $urandom;
    bus.start = 1'b1;
    bus.op_signed = sg;
    bus.rs_val = a;
    bus.rt_val = b;
    bus.hi_we = hiws;
    bus.wdata = w;
    exp_q.push_back(ref_prod(sg, a, b));
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    if (hiws) chk("mthi_with_start", {32'd0, bus.hi}, {32'd0, w});
    n = 0;
    while (bus.busy && n < 40) begin
      n++;
      if (lowe && n == 2) chk("mtlo_in_wait", {32'd0, bus.lo}, {32'd0, lo_before});
      bus.start = inj && (n == 1);
      bus.lo_we = lowe && (n == 1);
      bus.wdata = $urandom;
      bus.rs_val = $urandom;
      bus.rt_val = $urandom;
      bus.op_signed = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.lo_we = 1'b0;
    chk("busy_cycles", 64'(n), 64'(W));
    chk("done_after_busy", {63'd0, bus.done}, 64'd1);
  endtask

  initial begin
    logic [31:0] corner [6];
    logic [31:0] a, b;
    int n;
    corner[0] = 32'h0000_0000; corner[1] = 32'h0000_0001; corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h8000_0000; corner[4] = 32'h7FFF_FFFF; corner[5] = 32'hFFFF_FFFD;
    checks = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op_signed = 1'b0; bus.rs_val = 32'd0; bus.rt_val = 32'd0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("rst_mul_ab", {bus.mul_a, bus.mul_b}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_mult(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    do_mult(1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0, 1'b0, 1'b0);
    do_mult(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    do_mult(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    do_mult(1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    do_mult(1'b0, 32'd2, 32'd3, 1'b1, 1'b0, 1'b0);
    do_mult(1'b0, 32'd4, 32'd5, 1'b0, 1'b0, 1'b0);
    chk("b2b_final", {bus.hi, bus.lo}, 64'h14);

    bus.hi_we = 1'b1;
    bus.wdata = 32'h1234_5678;
    @(negedge clk);
    bus.hi_we = 1'b0;
    chk("mthi_idle", {32'd0, bus.hi}, 64'h1234_5678);
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'hA5A5_0F0F;
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    chk("mthi_mtlo_both", {bus.hi, bus.lo}, 64'hA5A5_0F0F_A5A5_0F0F);

    do_mult(1'b0, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b1, 1'b0);
    do_mult(1'b1, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : 32'($urandom);
      b = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : 32'($urandom);
      do_mult(1'($urandom_range(0, 1)), a, b, ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end

    // Reset in the middle of WAIT: outputs clear at once, no done follows.
    bus.start = 1'b1;
    bus.op_signed = 1'b0;
    bus.rs_val = 32'd5;
    bus.rt_val = 32'd7;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
    chk("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("midrst_mul_ab", {bus.mul_a, bus.mul_b}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
